boxcar_decim_w16: RTL and testbench
===================================

// Module: boxcar_decim_w16
// PURPOSE
//  Accumulate-and-dump decimator for the FM baseband path. It pops signed 16-bit samples
//  from an upstream fifo_w16 read port and sums DECIM consecutive samples. Each sum is
//  rounded, right-shifted by SHIFT and saturated to 16 bits, then pushed into a downstream
//  fifo_w16 write port. One output is produced per DECIM inputs; both sides use the
//  empty_n/read and full_n/write FIFO handshake.
// PARAMETERS
//  DECIM      8   samples summed per output; legal range 2..256
//  SHIFT      3   arithmetic right shift applied to the rounded sum; legal range 0..ACC_WIDTH-16
//  ACC_WIDTH  24  accumulator width; must be >= 16+clog2(DECIM)
//  CNT_WIDTH  8   sample-counter width; must be >= clog2(DECIM)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  in_empty_n  in   1   upstream FIFO has data
//  in_read     out  1   pop request to upstream FIFO
//  in_dout     in   16  upstream FIFO head sample, signed
//  out_full_n  in   1   downstream FIFO has space
//  out_write   out  1   push request to downstream FIFO
//  out_din     out  16  decimated sample, signed
//  sat_flag    out  1   sticky: set when any output saturated; cleared only by reset
// BEHAVIOUR
//  - Interface: one clock, clk; reset is asynchronous and active-high, port reset.
//  - Reset values: acc=0, cnt=0, out_valid=0, out_din=0, sat_flag=0,
//    in_read=0, out_write=0.
//  - Definitions:
//    - pop = in_read & in_empty_n
//    - push = out_write & out_full_n
//    - out_write = out_valid (registered).
//  - Input handshake (combinational):
//    - in_read = in_empty_n & ~(cnt==DECIM-1 & out_valid & ~out_full_n).
//    - The block stalls input only when the last sample of a group is ready, the output
//      register is occupied and the output cannot drain this cycle.
//    - At most one pop per cycle. in_dout is used in the same cycle as pop (FIFO
//      show-ahead).
//  - On pop:
//    - x = sign-extend(in_dout) to ACC_WIDTH.
//    - sum = (cnt==0) ? x : acc + x.
//    - If cnt < DECIM-1: acc <= sum; cnt <= cnt+1.
//    - If cnt == DECIM-1:
//      - acc <= 0; cnt <= 0.
//      - r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift; round half
//        toward +inf).
//      - out_din <= clamp(r, -32768, 32767); out_valid <= 1.
//      - sat_flag <= sat_flag | clamped.
//  - Output:
//    - On push with no simultaneous group completion: out_valid <= 0.
//    - Push and completion in the same cycle: out_din and out_valid take the new
//      sample, so out_valid stays 1. The previous word has just been accepted downstream.
//  - Latency: out_write rises 1 cycle after the pop of the DECIM-th sample.
//  - Throughput: 1 sample/cycle in; no bubbles while out_full_n=1.
//  - Boundaries:
//    - Upstream empty mid-group: acc and cnt hold; the group continues when data
//      returns.
//    - Downstream full: out_din and out_valid hold stable until accepted. Input pops
//      continue through samples 0..DECIM-2 of the next group, then stall.
//    - No sample is dropped or duplicated.
//    - Asynchronous reset mid-group or mid-push: the partial sum is discarded and all
//      state returns to reset values immediately. The first pop after reset starts a
//      new group.
//  - Counter wrap: cnt never exceeds DECIM-1.
// TESTING
//  1. DECIM=8,SHIFT=3; 8 pops of 100, out_full_n=1
//     -> one push out_din=100, 1 cycle after 8th pop; sat_flag=0.
//  2. Rounding: groups {4,0x7} -> 1; {3,0x7} -> 0; {-4,0x7} -> 0; {-5,0x7} -> -1.
//  3. Extremes: 8x32767 -> 32767; 8x(-32768) -> -32768; sat_flag stays 0.
//     SHIFT=2 instance: 8x20000 -> 32767, sat_flag=1 until reset.
//  4. Backpressure: continuous input, out_full_n=0 for 20 cycles.
//     -> exactly 7 further pops, then in_read=0; out_din stable.
//     On release: the held word is pushed and streaming resumes. Output sequence is
//     identical to the unstalled run.
//  5. Bubbles: in_empty_n random 50%, out_full_n random 70%, 1000 samples
//     -> 125 outputs matching the reference model; no loss or duplication.
//  6. Assert reset after 5 pops of a group, then feed 8x7
//     -> single output 7; out_write low during and right after reset.

Source files
------------

// File: rtl/boxcar_decim_w16.sv
// Accumulate-and-dump decimator: sums DECIM signed samples, then rounds, shifts and
// saturates the sum to 16 bits. FIFO-style handshakes on both sides.
module boxcar_decim_w16 #(
  parameter int DECIM     = 8,
  parameter int SHIFT     = 3,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_empty_n,
  output logic        in_read,
  input  logic [15:0] in_dout,
  input  logic        out_full_n,
  output logic        out_write,
  output logic [15:0] out_din,
  output logic        sat_flag
);

  localparam int RW = ACC_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DECIM - 1);
  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] MAXV = RW'(32767);
  localparam logic signed [RW-1:0] MINV = RW'(-32768);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic [15:0]                 dout_q, dout_d;
  logic                        sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0] x, sum;
  logic signed [RW-1:0]        rnd, r;
  logic                        last, stall, pop, push, sat_hi, sat_lo;

  assign last  = (cnt_q == LAST);
  // Only the group-closing sample waits for the output register to drain.
  assign stall = last & out_valid_q & ~out_full_n;
  assign in_read = ~reset & in_empty_n & ~stall;
  assign pop   = in_read & in_empty_n;
  assign push  = out_valid_q & out_full_n;

  assign x   = {{(ACC_WIDTH-16){in_dout[15]}}, in_dout};
  assign sum = (cnt_q == '0) ? x : acc_q + x;
  // One guard bit so the rounding increment cannot wrap the accumulator.
  assign rnd = {sum[ACC_WIDTH-1], sum} + RND;
  assign r   = rnd >>> SHIFT;
  assign sat_hi = (r > MAXV);
  assign sat_lo = (r < MINV);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    out_valid_d = push ? 1'b0 : out_valid_q;
    if (pop) begin
      if (last) begin
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        dout_d      = sat_hi ? 16'h7fff : (sat_lo ? 16'h8000 : r[15:0]);
        sat_d       = sat_q | sat_hi | sat_lo;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
    end
  end

  assign out_write = out_valid_q;
  assign out_din   = dout_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_boxcar_decim_w16.sv
// Scoreboard bench for boxcar_decim_w16: directed groups with hand-computed results,
// backpressure, random bubbles and mid-group reset; a SHIFT=2 instance checks saturation.
module tb_boxcar_decim_w16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_empty_n, in_read, out_full_n, out_write, sat_flag;
  logic [15:0] in_dout, out_din;
  logic        e2_empty_n, in_read2, out_full2_n, out_write2, sat_flag2;
  logic [15:0] in_dout2, out_din2;

  boxcar_decim_w16 #(.DECIM(8), .SHIFT(3), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_empty_n(in_empty_n), .in_read(in_read), .in_dout(in_dout),
    .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din),
    .sat_flag(sat_flag));

  boxcar_decim_w16 #(.DECIM(8), .SHIFT(2), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset),
    .in_empty_n(e2_empty_n), .in_read(in_read2), .in_dout(in_dout2),
    .out_full_n(out_full2_n), .out_write(out_write2), .out_din(out_din2),
    .sat_flag(sat_flag2));

  logic signed [15:0] inq[$];
  logic signed [15:0] expq[$];
  int n_vec = 0, n_err = 0;
  int full_mode = 1;      // 0: always full, 1: always space, 2: 70% space
  bit rand_empty = 0;
  int pops = 0;
  int grp = 0;
  bit chk_next = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic send(input int s[8], input int e);
    foreach (s[i]) inq.push_back(16'(s[i]));
    expq.push_back(16'(e));
  endtask

  task automatic send_raw(input int v, input int n);
    for (int i = 0; i < n; i++) inq.push_back(16'(v));
  endtask

  task automatic drain();
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (inq.size() == 0 && expq.size() == 0 && !out_write) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: got %0d words pending, required 0", expq.size());
  endtask

  // Upstream show-ahead FIFO and downstream space model
  initial begin
    in_empty_n = 1'b0;
    in_dout    = '0;
    out_full_n = 1'b1;
    forever begin
      @(negedge clk);
      in_empty_n = (inq.size() > 0) && (!rand_empty || $urandom_range(0, 1) == 1);
      in_dout    = (inq.size() > 0) ? inq[0] : '0;
      case (full_mode)
        0:       out_full_n = 1'b0;
        1:       out_full_n = 1'b1;
        default: out_full_n = ($urandom_range(0, 9) < 7);
      endcase
      #1;
      if (in_read && in_empty_n) begin
        void'(inq.pop_front());
        pops++;
      end
    end
  end

  // Monitor: compares every push against the scoreboard and checks output latency
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        grp      = 0;
        chk_next = 0;
      end else begin
        if (chk_next) begin
          check("latency_out_write", int'(out_write), 1);
          chk_next = 0;
        end
        if (out_write && out_full_n) begin
          if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_push: got out_din=%0d, required no push", $signed(out_din));
          end else begin
            check("out_din", int'($signed(out_din)), int'(expq.pop_front()));
          end
        end
        if (in_read && in_empty_n) begin
          grp++;
          if (grp == 8) begin
            grp      = 0;
            chk_next = 1;
          end
        end
      end
    end
  end

  initial begin
    int p0, v, w;
    reset       = 1'b1;
    e2_empty_n  = 1'b1;
    in_dout2    = '0;
    out_full2_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_write", int'(out_write), 0);
    check("rst_out_din", int'(out_din), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_in_read", int'(in_read2), 0);
    @(negedge clk);
    reset = 1'b0;

    // SHIFT=2: 8 x 20000 -> (160000+2)>>2 = 40000 -> saturates
    in_dout2 = 16'd20000;
    repeat (8) @(negedge clk);
    e2_empty_n = 1'b0;
    #1;
    check("sat2_out_write", int'(out_write2), 1);
    check("sat2_out_din", int'($signed(out_din2)), 32767);
    check("sat2_flag", int'(sat_flag2), 1);

    send('{100, 100, 100, 100, 100, 100, 100, 100}, 100);
    send('{4, 0, 0, 0, 0, 0, 0, 0}, 1);
    send('{3, 0, 0, 0, 0, 0, 0, 0}, 0);
    send('{-4, 0, 0, 0, 0, 0, 0, 0}, 0);
    send('{-5, 0, 0, 0, 0, 0, 0, 0}, -1);
    send('{1, 2, 3, 4, 5, 6, 7, 8}, 5);
    send('{10, 20, 30, 40, 50, 60, 70, 80}, 45);
    send('{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}, 32767);
    send('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}, -32768);
    drain();
    check("sat_flag_no_clamp", int'(sat_flag), 0);
    check("sat2_sticky", int'(sat_flag2), 1);

    // Backpressure: 8 pops complete a group, 7 more pops, then stall
    full_mode = 0;
    p0 = pops;
    send('{-50, -50, -50, -50, -50, -50, -50, -50}, -50);
    send('{1, 2, 3, 4, 5, 6, 7, 8}, 5);
    send('{9, 9, 9, 9, 9, 9, 9, 9}, 9);
    repeat (12) @(negedge clk);
    #2;
    check("bp_hold_mid", int'($signed(out_din)), -50);
    repeat (8) @(negedge clk);
    #2;
    check("bp_pops", pops - p0, 15);
    check("bp_in_read", int'(in_read), 0);
    check("bp_out_write", int'(out_write), 1);
    check("bp_hold_end", int'($signed(out_din)), -50);
    full_mode = 1;
    drain();

    // Random bubbles both sides: 125 groups, zero-sum offsets keep result = v
    rand_empty = 1;
    full_mode  = 2;
    for (int g = 0; g < 125; g++) begin
      v = (g * 263) % 4001 - 2000;
      send('{v + 3, v - 3, v + 1, v - 1, v + 2, v - 2, v, v}, v);
    end
    drain();
    rand_empty = 0;
    full_mode  = 1;

    // Reset with an output word held and 5 samples of the next group absorbed
    full_mode = 0;
    send_raw(11, 13);
    for (int i = 0; i < 200 && inq.size() > 0; i++) @(negedge clk);
    check("pre_rst_out_write", int'(out_write), 1);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_out_write", int'(out_write), 0);
    check("async_rst_out_din", int'(out_din), 0);
    check("async_rst_sat2", int'(sat_flag2), 0);
    full_mode = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    check("post_rst_out_write", int'(out_write), 0);
    send('{7, 7, 7, 7, 7, 7, 7, 7}, 7);
    drain();
    w = expq.size();
    check("scoreboard_empty", w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
